// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-master Wishbone B4 pipelined arbiter with outstanding tracking and watchdog
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   mN_cyc_i/stb_i/we_i         master N (N=0,1) cycle, strobe, write
//   mN_adr_i/dat_i/sel_i        master N address, write data, byte enables
//   mN_dat_o                    read data returned to master N
//   mN_ack_o/stall_o/err_o      acknowledge, stall, error to master N
//   wb_cyc_o/stb_o/we_o         shared slave cycle, strobe, write
//   wb_adr_o/dat_o/sel_o        shared slave address, write data, byte enables
//   wb_dat_i, wb_ack_i,
//   wb_stall_i, wb_err_i        slave read data and responses

`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

module wb_arb2 #(
  parameter int OUTST_MAX = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,

  input  logic                        m0_cyc_i,
  input  logic                        m0_stb_i,
  input  logic                        m0_we_i,
  input  logic [`CORE_ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [`CORE_DATA_WIDTH-1:0] m0_dat_i,
  input  logic [`CORE_BE_WIDTH-1:0]   m0_sel_i,
  output logic [`CORE_DATA_WIDTH-1:0] m0_dat_o,
  output logic                        m0_ack_o,
  output logic                        m0_stall_o,
  output logic                        m0_err_o,

  input  logic                        m1_cyc_i,
  input  logic                        m1_stb_i,
  input  logic                        m1_we_i,
  input  logic [`CORE_ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [`CORE_DATA_WIDTH-1:0] m1_dat_i,
  input  logic [`CORE_BE_WIDTH-1:0]   m1_sel_i,
  output logic [`CORE_DATA_WIDTH-1:0] m1_dat_o,
  output logic                        m1_ack_o,
  output logic                        m1_stall_o,
  output logic                        m1_err_o,

  output logic                        wb_cyc_o,
  output logic                        wb_stb_o,
  output logic                        wb_we_o,
  output logic [`CORE_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [`CORE_DATA_WIDTH-1:0] wb_dat_o,
  output logic [`CORE_BE_WIDTH-1:0]   wb_sel_o,
  input  logic [`CORE_DATA_WIDTH-1:0] wb_dat_i,
  input  logic                        wb_ack_i,
  input  logic                        wb_stall_i,
  input  logic                        wb_err_i
);

  localparam int OW = $clog2(OUTST_MAX) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [OW-1:0] OUTST_FULL = OW'(OUTST_MAX);
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last_gnt;
  logic [OW-1:0]   outst, outst_nxt;
  logic [WW-1:0]   wdog, wdog_nxt;

  logic            gnt0, gnt1, granted;
  logic            sel_cyc, sel_stb;
  logic            full, has_outst, resp, resp_valid;
  logic            abort, accept, release_gnt;

  always_comb begin
    gnt0       = (state == GNT0);
    gnt1       = (state == GNT1);
    granted    = gnt0 | gnt1;

    sel_cyc    = gnt1 ? m1_cyc_i : m0_cyc_i;
    sel_stb    = gnt1 ? m1_stb_i : m0_stb_i;

    full       = (outst == OUTST_FULL);
    has_outst  = (outst != '0);
    resp       = wb_ack_i | wb_err_i;
    // A response with nothing outstanding is stale (post-abort or post-reset) and is dropped.
    resp_valid = granted & resp & has_outst;

    // A response arriving in the expiry cycle clears the watchdog instead of aborting.
    abort      = granted & has_outst & ~resp & (wdog == WDOG_LIMIT);

    // The grant is being released on abort, so no new transfer is issued in that cycle.
    wb_stb_o   = granted & sel_cyc & sel_stb & ~full & ~abort;
    accept     = wb_stb_o & ~wb_stall_i;

    outst_nxt = outst;
    if (abort) begin
      outst_nxt = '0;
    end else if (accept & ~resp_valid) begin
      outst_nxt = outst + OW'(1);
    end else if (resp_valid & ~accept) begin
      outst_nxt = outst - OW'(1);
    end

    if (abort | resp | ~has_outst) begin
      wdog_nxt = '0;
    end else begin
      wdog_nxt = wdog + WW'(1);
    end

    // Releasing on the final drain response avoids holding wb_cyc_o an extra cycle.
    release_gnt = abort | (~sel_cyc & (outst_nxt == '0));

    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i & m1_cyc_i) begin
          state_nxt = last_gnt ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (release_gnt) state_nxt = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (release_gnt) state_nxt = m0_cyc_i ? GNT0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      outst    <= '0;
      wdog     <= '0;
    end else begin
      state <= state_nxt;
      outst <= outst_nxt;
      wdog  <= wdog_nxt;
      if (state_nxt != state) begin
        if (state_nxt == GNT0) last_gnt <= 1'b0;
        else if (state_nxt == GNT1) last_gnt <= 1'b1;
      end
    end
  end

  always_comb begin
    wb_cyc_o   = granted;
    wb_we_o    = gnt1 ? m1_we_i  : m0_we_i;
    wb_adr_o   = gnt1 ? m1_adr_i : m0_adr_i;
    wb_dat_o   = gnt1 ? m1_dat_i : m0_dat_i;
    wb_sel_o   = gnt1 ? m1_sel_i : m0_sel_i;

    m0_dat_o   = wb_dat_i;
    m1_dat_o   = wb_dat_i;

    m0_ack_o   = gnt0 & wb_ack_i & has_outst;
    m1_ack_o   = gnt1 & wb_ack_i & has_outst;
    m0_err_o   = gnt0 & ((wb_err_i & has_outst) | abort);
    m1_err_o   = gnt1 & ((wb_err_i & has_outst) | abort);

    m0_stall_o = ~gnt0 | wb_stall_i | full | abort;
    m1_stall_o = ~gnt1 | wb_stall_i | full | abort;
  end

endmodule

// File: tb/tb_wb_arb2.sv
// tb/tb_wb_arb2.sv - directed vector bench for wb_arb2

`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

module tb_wb_arb2;

  logic wb_clk_i = 1'b0;
  logic wb_rst_n_i;

  logic                        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [`CORE_ADDR_WIDTH-1:0] m0_adr_i;
  logic [`CORE_DATA_WIDTH-1:0] m0_dat_i;
  logic [`CORE_BE_WIDTH-1:0]   m0_sel_i;
  logic [`CORE_DATA_WIDTH-1:0] m0_dat_o;
  logic                        m0_ack_o, m0_stall_o, m0_err_o;

  logic                        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [`CORE_ADDR_WIDTH-1:0] m1_adr_i;
  logic [`CORE_DATA_WIDTH-1:0] m1_dat_i;
  logic [`CORE_BE_WIDTH-1:0]   m1_sel_i;
  logic [`CORE_DATA_WIDTH-1:0] m1_dat_o;
  logic                        m1_ack_o, m1_stall_o, m1_err_o;

  logic                        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [`CORE_ADDR_WIDTH-1:0] wb_adr_o;
  logic [`CORE_DATA_WIDTH-1:0] wb_dat_o;
  logic [`CORE_BE_WIDTH-1:0]   wb_sel_o;
  logic [`CORE_DATA_WIDTH-1:0] wb_dat_i;
  logic                        wb_ack_i, wb_stall_i, wb_err_i;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_arb2 #(.OUTST_MAX(8), .TIMEOUT(255)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .m0_cyc_i   (m0_cyc_i),
    .m0_stb_i   (m0_stb_i),
    .m0_we_i    (m0_we_i),
    .m0_adr_i   (m0_adr_i),
    .m0_dat_i   (m0_dat_i),
    .m0_sel_i   (m0_sel_i),
    .m0_dat_o   (m0_dat_o),
    .m0_ack_o   (m0_ack_o),
    .m0_stall_o (m0_stall_o),
    .m0_err_o   (m0_err_o),
    .m1_cyc_i   (m1_cyc_i),
    .m1_stb_i   (m1_stb_i),
    .m1_we_i    (m1_we_i),
    .m1_adr_i   (m1_adr_i),
    .m1_dat_i   (m1_dat_i),
    .m1_sel_i   (m1_sel_i),
    .m1_dat_o   (m1_dat_o),
    .m1_ack_o   (m1_ack_o),
    .m1_stall_o (m1_stall_o),
    .m1_err_o   (m1_err_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_stall_i (wb_stall_i),
    .wb_err_i   (wb_err_i)
  );

  // in  = {m0_cyc, m0_stb, m1_cyc, m1_stb, ack, err, stall}
  // exp = {wb_cyc, wb_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err}
  typedef struct {
    logic [6:0] in;
    logic [7:0] exp;
    logic       gnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  localparam logic [7:0] RST_OUT = 8'b0011_0000;

  function automatic logic [7:0] outs();
    return {wb_cyc_o, wb_stb_o, m0_stall_o, m1_stall_o,
            m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc_in(input logic [6:0] v);
    @(negedge wb_clk_i);
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, wb_ack_i, wb_err_i, wb_stall_i} = v;
    #4;
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, wb_ack_i, wb_err_i, wb_stall_i} = 7'b0;
    wb_rst_n_i = 1'b0;
    #4;
    chk("reset_outputs", 32'(outs()), 32'(RST_OUT));
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
  endtask

  initial begin
    int first_err;
    int err_cnt;
    logic cyc_after;

    wb_rst_n_i = 1'b0;
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, wb_ack_i, wb_err_i, wb_stall_i} = 7'b0;
    m0_we_i  = 1'b1;
    m1_we_i  = 1'b0;
    m0_adr_i = 32'h0000_00A0;
    m1_adr_i = 32'h0000_00B1;
    m0_dat_i = 32'h1111_0000;
    m1_dat_i = 32'h2222_0000;
    m0_sel_i = 4'h3;
    m1_sel_i = 4'hC;
    wb_dat_i = 32'hCAFE_F00D;

    vecs[0]  = '{7'b0000000, 8'b0011_0000, 1'b0};
    vecs[1]  = '{7'b1111000, 8'b0011_0000, 1'b0};
    vecs[2]  = '{7'b1111000, 8'b1101_0000, 1'b0};
    vecs[3]  = '{7'b1011100, 8'b1001_1000, 1'b0};
    vecs[4]  = '{7'b0011000, 8'b1001_0000, 1'b0};
    vecs[5]  = '{7'b0011000, 8'b1110_0000, 1'b1};
    vecs[6]  = '{7'b0011001, 8'b1111_0000, 1'b1};
    vecs[7]  = '{7'b0000100, 8'b1010_0100, 1'b1};
    vecs[8]  = '{7'b0000000, 8'b0011_0000, 1'b0};
    vecs[9]  = '{7'b0000100, 8'b0011_0000, 1'b0};
    vecs[10] = '{7'b1000000, 8'b0011_0000, 1'b0};
    vecs[11] = '{7'b0000000, 8'b1001_0000, 1'b0};
    vecs[12] = '{7'b1010000, 8'b0011_0000, 1'b0};
    vecs[13] = '{7'b1111000, 8'b1110_0000, 1'b1};
    vecs[14] = '{7'b1110010, 8'b1010_0001, 1'b1};
    vecs[15] = '{7'b1100000, 8'b1010_0000, 1'b1};
    vecs[16] = '{7'b1100000, 8'b1101_0000, 1'b0};
    vecs[17] = '{7'b0000000, 8'b1001_0000, 1'b0};
    vecs[18] = '{7'b0000100, 8'b1001_1000, 1'b0};
    vecs[19] = '{7'b0000000, 8'b0011_0000, 1'b0};
    vecs[20] = '{7'b0011000, 8'b0011_0000, 1'b0};
    vecs[21] = '{7'b0011010, 8'b1110_0000, 1'b1};
    vecs[22] = '{7'b0000100, 8'b1010_0100, 1'b1};
    vecs[23] = '{7'b0000000, 8'b0011_0000, 1'b0};

    // Table: arbitration, round-robin, back-to-back handover, drain, stray responses.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      cyc_in(vecs[i].in);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      if (vecs[i].exp[7]) begin
        chk($sformatf("vec%0d_bus", i), {23'b0, wb_we_o, wb_adr_o[7:0]},
            vecs[i].gnt ? {23'b0, 1'b0, 8'hB1} : {23'b0, 1'b1, 8'hA0});
        chk($sformatf("vec%0d_wdat", i), wb_dat_o,
            vecs[i].gnt ? 32'h2222_0000 : 32'h1111_0000);
      end
    end
    chk("rdata_m0", m0_dat_o, 32'hCAFE_F00D);
    chk("rdata_m1", m1_dat_o, 32'hCAFE_F00D);

    // Outstanding limit, refill after one ack, simultaneous ack+accept at outst=4.
    do_reset();
    cyc_in(7'b1100000);
    for (int i = 0; i < 8; i++) begin
      cyc_in(7'b1100000);
      chk($sformatf("fill%0d", i), {30'b0, wb_stb_o, m0_stall_o}, 32'b10);
    end
    cyc_in(7'b1100000);
    chk("full_stall", {30'b0, wb_stb_o, m0_stall_o}, 32'b01);
    cyc_in(7'b1100100);
    chk("full_ack", {29'b0, wb_stb_o, m0_stall_o, m0_ack_o}, 32'b011);
    cyc_in(7'b1100000);
    chk("refill", {30'b0, wb_stb_o, m0_stall_o}, 32'b10);
    cyc_in(7'b1100000);
    chk("full_again", {30'b0, wb_stb_o, m0_stall_o}, 32'b01);
    for (int i = 0; i < 4; i++) begin
      cyc_in(7'b1000100);
      chk($sformatf("drain8to4_%0d", i), {31'b0, m0_ack_o}, 32'b1);
    end
    cyc_in(7'b1100100);
    chk("ack_and_stb", {30'b0, wb_stb_o, m0_ack_o}, 32'b11);
    cyc_in(7'b0000000);
    chk("hold4", {31'b0, wb_cyc_o}, 32'b1);
    for (int i = 0; i < 4; i++) begin
      cyc_in(7'b0000100);
      chk($sformatf("drain4_%0d", i), {30'b0, wb_cyc_o, m0_ack_o}, 32'b11);
    end
    cyc_in(7'b0000000);
    chk("drained4_idle", 32'(outs()), 32'(RST_OUT));

    // m1 drops cyc with three outstanding.
    do_reset();
    cyc_in(7'b0011000);
    for (int i = 0; i < 3; i++) begin
      cyc_in(7'b0011000);
      chk($sformatf("m1_issue%0d", i), {30'b0, wb_stb_o, m1_stall_o}, 32'b10);
    end
    for (int i = 0; i < 2; i++) begin
      cyc_in(7'b0000000);
      chk($sformatf("m1_hold%0d", i), {30'b0, wb_cyc_o, wb_stb_o}, 32'b10);
    end
    for (int i = 0; i < 3; i++) begin
      cyc_in(7'b0000100);
      chk($sformatf("m1_drain%0d", i), {30'b0, wb_cyc_o, m1_ack_o}, 32'b11);
    end
    cyc_in(7'b0000000);
    chk("m1_drained_idle", 32'(outs()), 32'(RST_OUT));

    // Watchdog: one outstanding read, slave silent.
    do_reset();
    cyc_in(7'b1100000);
    cyc_in(7'b1100000);
    chk("wd_issue", {31'b0, wb_stb_o}, 32'b1);
    first_err = -1;
    err_cnt   = 0;
    cyc_after = 1'b1;
    for (int n = 0; n < 300; n++) begin
      cyc_in(7'b1000000);
      if (m0_err_o) begin
        err_cnt++;
        if (first_err < 0) first_err = n;
      end
      if (first_err >= 0 && n == first_err + 1) cyc_after = wb_cyc_o;
    end
    chk("wd_first_err", 32'(first_err), 32'd255);
    chk("wd_err_count", 32'(err_cnt), 32'd1);
    chk("wd_release", {31'b0, cyc_after}, 32'b0);
    cyc_in(7'b0000100);
    chk("wd_late_ack", {30'b0, m0_ack_o, m0_err_o}, 32'b0);

    // Reset asserted mid-burst.
    do_reset();
    cyc_in(7'b1100000);
    cyc_in(7'b1100000);
    cyc_in(7'b1100000);
    @(negedge wb_clk_i);
    #2;
    wb_rst_n_i = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 32'(RST_OUT));
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, wb_ack_i, wb_err_i, wb_stall_i} = 7'b0000100;
    #4;
    chk("rst_no_ack0", 32'(outs()), 32'(RST_OUT));
    cyc_in(7'b0000100);
    chk("rst_no_ack1", 32'(outs()), 32'(RST_OUT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
